// File: rtl/delay_tap_if.sv
// Pixel-pipeline delay-line bus: sample stream in, delayed stream out, tap config handshake.
// No storage; backpressure exists only on the cfg_valid/cfg_ready pair.
interface delay_tap_if #(
    parameter int WIDTH = 1,
    parameter int TAP_W = 5
);
    logic             en;
    logic [WIDTH-1:0] din;
    logic             frame_start;
    logic [TAP_W-1:0] cfg_delay;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [TAP_W-1:0] cur_delay;
    logic             busy;

    modport slave (
        input  en, din, frame_start, cfg_delay, cfg_valid,
        output cfg_ready, dout, dout_valid, cur_delay, busy
    );

    modport master (
        output en, din, frame_start, cfg_delay, cfg_valid,
        input  cfg_ready, dout, dout_valid, cur_delay, busy
    );
endinterface

// File: rtl/delay_tap_ctrl.sv
// Programmable-tap delay line; tap changes only on a frame boundary, then flushes.
// Latency: cur_delay enabled clocks from din to dout; dout blanked during flush.
// Backpressure: cfg_ready drops from acceptance of a new tap until the flush completes.
module delay_tap_ctrl #(
    parameter int WIDTH         = 1,
    parameter int MAX_DELAY     = 16,
    parameter int TAP_W         = 5,
    parameter int DEFAULT_DELAY = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    delay_tap_if.slave  bus
);
    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

    localparam logic [TAP_W-1:0] MAX_D = TAP_W'(MAX_DELAY);
    localparam logic [TAP_W-1:0] DEF_D = TAP_W'(DEFAULT_DELAY);
    localparam logic [TAP_W-1:0] ONE   = TAP_W'(1);

    state_t                          state_q, state_d;
    logic [MAX_DELAY-1:0][WIDTH-1:0] sr_q, sr_d;
    logic [TAP_W-1:0]                cur_delay_q, cur_delay_d;
    logic [TAP_W-1:0]                pend_delay_q, pend_delay_d;
    logic [TAP_W-1:0]                fill_cnt_q, fill_cnt_d;
    logic                            cfg_ready_q, cfg_ready_d;
    logic                            dout_valid_q, dout_valid_d;
    logic                            busy_q, busy_d;
    logic [TAP_W-1:0]                cfg_clamped;
    logic [TAP_W-1:0]                tap_idx;
    logic [WIDTH-1:0]                tap_dat;

    always_comb begin
        sr_d = sr_q;
        if (bus.en) begin
            sr_d[0] = bus.din;
            for (int i = 1; i < MAX_DELAY; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_comb begin
        cfg_clamped = bus.cfg_delay;
        if (bus.cfg_delay == '0) begin
            cfg_clamped = ONE;
        end else if (bus.cfg_delay > MAX_D) begin
            cfg_clamped = MAX_D;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_delay_d  = cur_delay_q;
        pend_delay_d = pend_delay_q;
        fill_cnt_d   = fill_cnt_q;
        case (state_q)
            RUN: begin
                // A frame_start coinciding with acceptance is deliberately ignored.
                if (bus.cfg_valid && cfg_clamped != cur_delay_q) begin
                    pend_delay_d = cfg_clamped;
                    state_d      = PEND;
                end
            end
            PEND: begin
                if (bus.frame_start) begin
                    cur_delay_d = pend_delay_q;
                    fill_cnt_d  = '0;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                if (bus.en) begin
                    if (fill_cnt_q == cur_delay_q - ONE) begin
                        state_d = RUN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + ONE;
                    end
                end
            end
            default: state_d = FLUSH;
        endcase
        cfg_ready_d  = (state_d == RUN);
        dout_valid_d = (state_d != FLUSH);
        busy_d       = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FLUSH;
            sr_q         <= '0;
            cur_delay_q  <= DEF_D;
            pend_delay_q <= DEF_D;
            fill_cnt_q   <= '0;
            cfg_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cur_delay_q  <= cur_delay_d;
            pend_delay_q <= pend_delay_d;
            fill_cnt_q   <= fill_cnt_d;
            cfg_ready_q  <= cfg_ready_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Tap mux written as a compare loop so the index width need not match the array depth.
    always_comb begin
        tap_idx = cur_delay_q - ONE;
        tap_dat = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (tap_idx == TAP_W'(i)) begin
                tap_dat = sr_q[i];
            end
        end
    end

    assign bus.dout       = dout_valid_q ? tap_dat : '0;
    assign bus.dout_valid = dout_valid_q;
    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.cur_delay  = cur_delay_q;
    assign bus.busy       = busy_q;
endmodule
